// File: rtl/fetch.sv
// Instruction fetch stage: single-outstanding req/ack fetch of the word at decode's PC.
// Optional misaligned-PC substitution is enabled with `define FETCH_MISALIGN_CHECK_EN.
module fetch #(
    parameter logic [31:0] RESET_INSTR    = 32'h00000013,
    parameter logic [7:0]  TIMEOUT_CYCLES = 8'd255
) (
    input  logic        i_CLK,
    input  logic        i_RSTn,
    input  logic        i_EN,
    input  logic [31:0] i_PC,
    output logic        o_INSTRUCTION_VALID,
    output logic [31:0] o_INSTRUCTION,
    output logic        o_IMEM_REQ,
    output logic [31:0] o_IMEM_ADDR,
    input  logic        i_IMEM_ACK,
    input  logic [31:0] i_IMEM_RDATA,
    output logic        o_IMEM_RETRY,
    output logic        o_MISALIGNED
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_addr, w_addr_nxt;
    logic [31:0] r_instr, w_instr_nxt;
    logic [7:0]  r_cnt, w_cnt_nxt;
    logic        r_valid, w_valid_nxt;
    logic        r_retry, w_retry_nxt;
    logic        r_misaligned, w_misaligned_nxt;

    always_ff @(posedge i_CLK) begin
        if (!i_RSTn) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_instr      <= RESET_INSTR;
            r_cnt        <= '0;
            r_valid      <= 1'b0;
            r_retry      <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_addr       <= w_addr_nxt;
            r_instr      <= w_instr_nxt;
            r_cnt        <= w_cnt_nxt;
            r_valid      <= w_valid_nxt;
            r_retry      <= w_retry_nxt;
            r_misaligned <= w_misaligned_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_addr_nxt       = r_addr;
        w_instr_nxt      = r_instr;
        w_cnt_nxt        = r_cnt;
        w_valid_nxt      = r_valid;
        w_retry_nxt      = 1'b0;
        w_misaligned_nxt = r_misaligned;
        case (r_state)
            IDLE: begin
                // Masking keeps the low PC bits out of the address in every build
                w_addr_nxt  = i_PC & 32'hFFFF_FFFC;
                w_cnt_nxt   = '0;
                w_state_nxt = REQ;
`ifdef FETCH_MISALIGN_CHECK_EN
                if (i_PC[1:0] != 2'b00) begin
                    w_state_nxt      = HOLD;
                    w_instr_nxt      = RESET_INSTR;
                    w_valid_nxt      = 1'b1;
                    w_misaligned_nxt = 1'b1;
                end
`endif
            end
            REQ: begin
                if (i_IMEM_ACK) begin
                    w_instr_nxt = i_IMEM_RDATA;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = HOLD;
                end else if (r_cnt == TIMEOUT_CYCLES - 8'd1) begin
                    w_retry_nxt = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            HOLD: begin
                if (r_valid && i_EN) begin
                    w_valid_nxt      = 1'b0;
                    w_misaligned_nxt = 1'b0;
                    w_state_nxt      = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign o_IMEM_REQ          = (r_state == REQ);
    assign o_IMEM_ADDR         = r_addr;
    assign o_INSTRUCTION       = r_instr;
    assign o_INSTRUCTION_VALID = r_valid;
    assign o_IMEM_RETRY        = r_retry;
    assign o_MISALIGNED        = r_misaligned;

endmodule
